// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared widths and typedefs for the operand fetch slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int DATA_W = 8;
  localparam int NREG   = 8;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [OP_W-1:0]   opcode_t;

endpackage

`default_nettype wire

// File: rtl/regfile_2r1w.sv
// ============================================================================
// Module      : regfile_2r1w
// Description : NREG x DATA_W register file, two async reads, one sync write,
//               cleared by synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r1w
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  data_t r_mem [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata1 = r_mem[raddr1];
  assign rdata2 = r_mem[raddr2];

endmodule

`default_nettype wire

// File: rtl/operand_fetch_unit.sv
// ============================================================================
// Module      : operand_fetch_unit
// Description : Register read, write-back forwarding, pending-write
//               scoreboard and 1-deep execute register.
//               Optional bypass enabled by macro OFU_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch_unit
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [OP_W-1:0]   id_op,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] ans_wb,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_op,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_rd_we,
  output logic [NREG-1:0]   busy_vec
);

  data_t           w_rdata1, w_rdata2, w_src1, w_src2;
  logic            w_fwd1, w_fwd2, w_wb_clr, w_hazard, w_issue;
  logic [NREG-1:0] r_busy, w_busy_nxt;

  logic            r_ex_valid, r_ex_rd_we;
  opcode_t         r_ex_op;
  data_t           r_ex_a, r_ex_b;
  reg_addr_t       r_ex_rd;

  regfile_2r1w u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (ans_wb),
    .raddr1 (id_rs1),
    .rdata1 (w_rdata1),
    .raddr2 (id_rs2),
    .rdata2 (w_rdata2)
  );

`ifdef OFU_BYPASS_EN
  assign w_fwd1 = wb_en && (wb_addr == id_rs1);
  assign w_fwd2 = wb_en && (wb_addr == id_rs2);
`else
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
`endif

  assign w_src1 = w_fwd1 ? ans_wb : w_rdata1;
  assign w_src2 = w_fwd2 ? ans_wb : w_rdata2;

  // A write-back landing on rd this cycle retires the older pending write (WAW).
  assign w_wb_clr = wb_en && (wb_addr == id_rd);
  assign w_hazard = (r_busy[id_rs1] && !w_fwd1) ||
                    (r_busy[id_rs2] && !w_fwd2) ||
                    (id_rd_we && r_busy[id_rd] && !w_wb_clr);
  assign id_ready = !w_hazard && (!r_ex_valid || ex_ready);
  assign w_issue  = id_valid && id_ready;

  // Set is applied after clear so a same-cycle set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en)                w_busy_nxt[wb_addr] = 1'b0;
    if (w_issue && id_rd_we)  w_busy_nxt[id_rd]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= '0;
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_rd    <= '0;
      r_ex_rd_we <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_issue) begin
        r_ex_valid <= 1'b1;
        r_ex_op    <= id_op;
        r_ex_a     <= w_src1;
        r_ex_b     <= w_src2;
        r_ex_rd    <= id_rd;
        r_ex_rd_we <= id_rd_we;
      end else if (r_ex_valid && ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_op    = r_ex_op;
  assign ex_op_a  = r_ex_a;
  assign ex_op_b  = r_ex_b;
  assign ex_rd    = r_ex_rd;
  assign ex_rd_we = r_ex_rd_we;
  assign busy_vec = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch_unit.sv
// ============================================================================
// Module      : tb_operand_fetch_unit
// Description : Self-checking bench for operand_fetch_unit (honours
//               OFU_BYPASS_EN), directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch_unit;
  import pipe_pkg::*;

`ifdef OFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0, id_rd_we = 1'b0, wb_en = 1'b0, ex_ready = 1'b1;
  logic [OP_W-1:0] id_op = '0;
  logic [ADDR_W-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_addr = '0;
  logic [DATA_W-1:0] ans_wb = '0;
  logic id_ready, ex_valid, ex_rd_we;
  logic [OP_W-1:0] ex_op;
  logic [DATA_W-1:0] ex_op_a, ex_op_b;
  logic [ADDR_W-1:0] ex_rd;
  logic [NREG-1:0] busy_vec;

  operand_fetch_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .wb_en(wb_en), .wb_addr(wb_addr), .ans_wb(ans_wb),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_rd(ex_rd),
    .ex_rd_we(ex_rd_we), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: plain arrays describing architectural contents.
  logic [7:0] m_mem [8];
  bit         m_busy [8];
  bit         m_ex_valid, m_ex_we, m_last_issue;
  logic [3:0] m_ex_op;
  logic [7:0] m_ex_a, m_ex_b;
  logic [2:0] m_ex_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] busy_word();
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = m_busy[i];
    return w;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = 8'h00;
      m_busy[i] = 1'b0;
    end
    m_ex_valid = 0; m_ex_we = 0; m_ex_op = 0; m_ex_a = 0; m_ex_b = 0; m_ex_rd = 0;
  endfunction

  // One clock: check id_ready before the edge, advance model, check outputs after.
  task automatic step();
    bit f1, f2, stall, rdy;
    logic [7:0] s1, s2;
    @(negedge clk);
    f1 = BYP && wb_en && (wb_addr == id_rs1);
    f2 = BYP && wb_en && (wb_addr == id_rs2);
    s1 = f1 ? ans_wb : m_mem[id_rs1];
    s2 = f2 ? ans_wb : m_mem[id_rs2];
    stall = (m_busy[id_rs1] && !f1) || (m_busy[id_rs2] && !f2) ||
            (id_rd_we && m_busy[id_rd] && !(wb_en && wb_addr == id_rd));
    rdy = !stall && (!m_ex_valid || ex_ready);
    if (!reset) check("id_ready", {31'b0, id_ready}, {31'b0, rdy});
    @(posedge clk);
    m_last_issue = 0;
    if (reset) begin
      model_reset();
    end else begin
      m_last_issue = id_valid && rdy;
      if (wb_en) m_busy[wb_addr] = 0;
      if (m_last_issue && id_rd_we) m_busy[id_rd] = 1;
      if (m_last_issue) begin
        m_ex_valid = 1; m_ex_op = id_op; m_ex_a = s1; m_ex_b = s2;
        m_ex_rd = id_rd; m_ex_we = id_rd_we;
      end else if (m_ex_valid && ex_ready) begin
        m_ex_valid = 0;
      end
      if (wb_en) m_mem[wb_addr] = ans_wb;
    end
    #1;
    check("ex_valid", {31'b0, ex_valid}, {31'b0, m_ex_valid});
    check("busy_vec", {24'b0, busy_vec}, {24'b0, busy_word()});
    if (m_ex_valid) begin
      check("ex_op",    {28'b0, ex_op},    {28'b0, m_ex_op});
      check("ex_op_a",  {24'b0, ex_op_a},  {24'b0, m_ex_a});
      check("ex_op_b",  {24'b0, ex_op_b},  {24'b0, m_ex_b});
      check("ex_rd",    {29'b0, ex_rd},    {29'b0, m_ex_rd});
      check("ex_rd_we", {31'b0, ex_rd_we}, {31'b0, m_ex_we});
    end
  endtask

  // Offer one instruction until accepted; any wb strobe lasts only the first cycle.
  task automatic issue(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic we, output int cyc);
    id_valid = 1; id_op = op; id_rs1 = a; id_rs2 = b; id_rd = d; id_rd_we = we;
    cyc = 0;
    m_last_issue = 0;
    while (!m_last_issue && cyc < 16) begin
      step();
      cyc++;
      wb_en = 0;
    end
    if (!m_last_issue) check("issue_timeout", 32'd0, 32'd1);
    id_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    model_reset();
    reset = 1;
    step(); step();
    reset = 0;
    check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_busy", {24'b0, busy_vec}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      issue(4'h1, 3'(i), 3'((i + 1) % 8), 3'd0, 1'b0, cyc);
      check("rst_reg_zero", {24'b0, ex_op_a}, 32'd0);
    end

    // Write then read the same register through both ports.
    wb_en = 1; wb_addr = 3; ans_wb = 8'h5A;
    step();
    wb_en = 0;
    issue(4'h2, 3'd3, 3'd3, 3'd0, 1'b0, cyc);
    check("wr_rd_a", {24'b0, ex_op_a}, 32'h5A);
    check("wr_rd_b", {24'b0, ex_op_b}, 32'h5A);

    // RAW on r2 resolved by a same-cycle write-back.
    issue(4'h3, 3'd0, 3'd0, 3'd2, 1'b1, cyc);
    step();
    wb_en = 1; wb_addr = 2; ans_wb = 8'h33;
    issue(4'h4, 3'd2, 3'd0, 3'd7, 1'b0, cyc);
    check("raw_cycles", 32'(cyc), BYP ? 32'd1 : 32'd2);
    check("raw_op_a", {24'b0, ex_op_a}, 32'h33);

    // WAW on r4: write-back and new writer in the same cycle, set wins.
    issue(4'h5, 3'd0, 3'd0, 3'd4, 1'b1, cyc);
    wb_en = 1; wb_addr = 4; ans_wb = 8'h44;
    issue(4'hB, 3'd5, 3'd6, 3'd4, 1'b1, cyc);
    check("waw_cycles", 32'(cyc), 32'd1);
    check("waw_busy4", {31'b0, busy_vec[4]}, 32'd1);

    // Backpressure holds the execute register and blocks issue.
    ex_ready = 0;
    id_valid = 1; id_op = 4'h6; id_rs1 = 5; id_rs2 = 6; id_rd = 0; id_rd_we = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_op", {28'b0, ex_op}, 32'hB);
    end
    ex_ready = 1;
    step();
    check("bp_release", {31'b0, m_last_issue}, 32'd1);
    check("bp_new_op", {28'b0, ex_op}, 32'h6);
    id_valid = 0;

    // Reset with an instruction held and writes pending on r1, r2.
    wb_en = 1; wb_addr = 4; ans_wb = 8'h00;
    step();
    wb_en = 0;
    issue(4'h7, 3'd0, 3'd0, 3'd1, 1'b1, cyc);
    issue(4'h8, 3'd0, 3'd0, 3'd2, 1'b1, cyc);
    check("mid_busy", {24'b0, busy_vec}, 32'h06);
    check("mid_valid", {31'b0, ex_valid}, 32'd1);
    reset = 1;
    step();
    reset = 0;
    check("mid_rst_valid", {31'b0, ex_valid}, 32'd0);
    check("mid_rst_busy", {24'b0, busy_vec}, 32'd0);

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      id_valid = $urandom_range(0, 3) != 0;
      id_op    = 4'($urandom);
      id_rs1   = 3'($urandom);
      id_rs2   = ($urandom_range(0, 3) == 0) ? id_rs1 : 3'($urandom);
      id_rd    = 3'($urandom);
      id_rd_we = $urandom_range(0, 1);
      wb_en    = $urandom_range(0, 1);
      wb_addr  = 3'($urandom);
      ans_wb   = 8'($urandom);
      ex_ready = $urandom_range(0, 3) != 0;
      step();
    end
    reset = 0; id_valid = 0; wb_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
